fp_add: RTL and testbench
=========================

FP_ADD -- requirements
Module: fp_add

Interface
REQ-001 Parameters: none; format fixed to IEEE-754 binary32.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  a/b valid this cycle.
REQ-005 a  input  32  addend, binary32 (sign[31], exp[30:23], frac[22:0]).
REQ-006 b  input  32  addend, binary32.
REQ-007 out_valid  output  1  result valid this cycle.
REQ-008 result  output  32  a+b, binary32, registered.

Function
REQ-009 The block SHALL be a 2-stage pipeline: operands sampled when in_valid=1 appear on result with out_valid=1 exactly 2 clk cycles later.
REQ-010 It SHALL accept a new operand pair every cycle, with no backpressure.
REQ-011 result SHALL hold its last value while out_valid=0.
REQ-012 Stage 1 SHALL unpack, insert the hidden bit, swap so the larger magnitude is first, align the smaller by the exponent difference, and add or subtract the 24-bit significands.
REQ-013 Alignment SHALL keep guard, round and sticky bits; shifts of 26 or more collapse the operand into sticky.
REQ-014 Stage 2 SHALL normalize: right shift by 1 on carry-out, else left shift by the leading-zero count, adjusting the exponent.
REQ-015 Rounding SHALL be round-to-nearest-even using guard/round/sticky; a rounding carry SHALL renormalize.
REQ-016 Subnormal inputs SHALL be treated as signed zero (flush-to-zero).
REQ-017 Results below the minimum normal SHALL flush to signed zero.
REQ-018 Exponent overflow after rounding SHALL produce signed infinity.
REQ-019 Any NaN input, or +inf plus -inf, SHALL produce quiet NaN 0x7FC00000.
REQ-020 inf plus a finite value SHALL produce that inf.
REQ-021 Exact cancellation, and zero plus zero, SHALL produce +0, except (-0)+(-0) = -0.
REQ-022 x plus ±0 SHALL return x unchanged (normal x).
REQ-023 The result sign SHALL be the sign of the larger-magnitude operand.

Reset
REQ-024 While rst=1, result SHALL be 32'h00000000, out_valid SHALL be 0, and all pipeline valid bits SHALL clear immediately.
REQ-025 Operations in flight when reset asserts SHALL be discarded.
REQ-026 After rst deasserts, the first valid output SHALL appear 2 cycles after the first sampled in_valid.

Structure
REQ-027 Package fp_add_pkg SHALL hold the field widths (EXP_W=8, FRAC_W=23), EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, and an unpacked-operand struct typedef.
REQ-028 Leading-zero count plus normalize shift SHALL be one sub-module, fp_add_norm (combinational).
REQ-029 All other logic SHALL reside in fp_add.

Verification (results checked 2 cycles after in_valid)
REQ-030 a=3f115b57, b=3fab851f -> result=3ff432ca.
REQ-031 Zero operands: a=00000000, b=3fab851f -> 3fab851f; a=00000000, b=00000000 -> 00000000.
REQ-032 Exact-tie rounding: a=3aa137f4, b=3c4985f0 -> 3c5dacee (tie to even).
REQ-033 Cancellation and specials: 3f800000+bf800000 -> 00000000; 7f800000+ff800000 -> 7fc00000; 7f7fffff+7f7fffff -> 7f800000.
REQ-034 Streaming: back-to-back in_valid over the vectors above -> results in order, one per cycle.
REQ-035 Mid-stream reset: assert rst mid-stream -> out_valid=0 and result=0 immediately, with no stale output after release.

Source files
------------

// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared constants, the unpacked-operand type and the unpack helper for the
// binary32 adder. No ports; imported by fp_add and fp_add_norm.
package fp_add_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned EXP_BIAS = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W:0]   mant;     // hidden bit included; zero for zero/subnormal
        logic              is_zero;  // true zero or subnormal (flushed)
        logic              is_inf;
        logic              is_nan;
    } fp_unpacked_t;

    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign    = x[31];
        u.is_zero = (x[30:23] == '0);
        u.is_inf  = (x[30:23] == EXP_MAX) && (x[22:0] == '0);
        u.is_nan  = (x[30:23] == EXP_MAX) && (x[22:0] != '0);
        // Subnormals are flushed: exponent and significand both forced to zero.
        u.exp     = u.is_zero ? '0 : x[30:23];
        u.mant    = u.is_zero ? '0 : {1'b1, x[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_add_norm.sv
// fp_add_norm: combinational leading-zero count and normalize shift.
// Ports:
//   sum     in  28  raw significand sum {carry, mant[23:0], guard, round, sticky}
//   norm    out 27  normalized {mant[23:0], guard, round, sticky}
//   carry   out 1   sum overflowed into bit 27 (normalized by a right shift of one)
//   lzc     out 5   left shift applied when no carry (27 when sum is zero)
//   is_zero out 1   sum is exactly zero
module fp_add_norm
    import fp_add_pkg::*;
(
    input  logic [27:0] sum,
    output logic [26:0] norm,
    output logic        carry,
    output logic [4:0]  lzc,
    output logic        is_zero
);

    logic found;

    always_comb begin
        carry   = sum[27];
        is_zero = (sum == '0);
        lzc     = 5'd0;
        found   = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (sum[i]) begin
                    found = 1'b1;
                end else begin
                    lzc = lzc + 5'd1;
                end
            end
        end
        if (carry) begin
            // Bit shifted out of the bottom folds into sticky.
            norm = {sum[27:2], sum[1] | sum[0]};
            lzc  = 5'd0;
        end else begin
            norm = sum[26:0] << lzc;
        end
    end

endmodule

// File: rtl/fp_add.sv
// fp_add: two-stage pipelined IEEE-754 binary32 adder, round-to-nearest-even, flush-to-zero.
// Ports:
//   clk       in  1   clock, rising edge
//   rst       in  1   asynchronous active-high reset
//   in_valid  in  1   a/b valid this cycle
//   a, b      in  32  binary32 addends
//   out_valid out 1   result valid this cycle (2 cycles after in_valid)
//   result    out 32  registered sum, holds while out_valid is low
module fp_add
    import fp_add_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] result
);

    // ---------------- Stage 1: unpack, swap, align, add ----------------
    fp_unpacked_t ua, ub;
    logic        a_ge_b;
    logic        big_sign;
    logic [7:0]  big_exp, sml_exp, exp_diff;
    logic [23:0] big_mant, sml_mant;
    logic        sml_zero;
    logic [49:0] sml_wide;
    logic [26:0] big_ext, sml_ext;
    logic        eff_sub;
    logic [27:0] sum;
    logic        special;
    logic [31:0] special_res;

    always_comb begin
        ua       = fp_unpack(a);
        ub       = fp_unpack(b);
        a_ge_b   = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
        big_sign = a_ge_b ? ua.sign : ub.sign;
        big_exp  = a_ge_b ? ua.exp  : ub.exp;
        big_mant = a_ge_b ? ua.mant : ub.mant;
        sml_exp  = a_ge_b ? ub.exp  : ua.exp;
        sml_mant = a_ge_b ? ub.mant : ua.mant;
        sml_zero = a_ge_b ? ub.is_zero : ua.is_zero;
        exp_diff = big_exp - sml_exp;

        // Upper 26 bits keep mant+guard+round; everything below collapses into sticky.
        sml_wide = {sml_mant, 26'd0} >> exp_diff;
        if (exp_diff >= 8'd26) begin
            sml_ext = {26'd0, ~sml_zero};
        end else begin
            sml_ext = {sml_wide[49:24], |sml_wide[23:0]};
        end
        big_ext = {big_mant, 3'b000};
        eff_sub = ua.sign ^ ub.sign;
        // big >= small by construction, so the difference never goes negative.
        sum = eff_sub ? ({1'b0, big_ext} - {1'b0, sml_ext})
                      : ({1'b0, big_ext} + {1'b0, sml_ext});

        special     = 1'b1;
        special_res = '0;
        if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && eff_sub)) begin
            special_res = QNAN;
        end else if (ua.is_inf) begin
            special_res = {ua.sign, EXP_MAX, 23'd0};
        end else if (ub.is_inf) begin
            special_res = {ub.sign, EXP_MAX, 23'd0};
        end else if (ua.is_zero && ub.is_zero) begin
            special_res = {ua.sign & ub.sign, 31'd0};
        end else if (ua.is_zero) begin
            special_res = b;
        end else if (ub.is_zero) begin
            special_res = a;
        end else begin
            special = 1'b0;
        end
    end

    logic        s1_valid_q;
    logic        s1_special_q;
    logic [31:0] s1_special_res_q;
    logic        s1_sign_q;
    logic [7:0]  s1_exp_q;
    logic [27:0] s1_sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q       <= 1'b0;
            s1_special_q     <= 1'b0;
            s1_special_res_q <= '0;
            s1_sign_q        <= 1'b0;
            s1_exp_q         <= '0;
            s1_sum_q         <= '0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_special_q     <= special;
                s1_special_res_q <= special_res;
                s1_sign_q        <= big_sign;
                s1_exp_q         <= big_exp;
                s1_sum_q         <= sum;
            end
        end
    end

    // ---------------- Stage 2: normalize, round, pack ----------------
    logic [26:0]       norm;
    logic              carry;
    logic [4:0]        lzc;
    logic              sum_zero;

    fp_add_norm u_norm (
        .sum     (s1_sum_q),
        .norm    (norm),
        .carry   (carry),
        .lzc     (lzc),
        .is_zero (sum_zero)
    );

    logic signed [9:0] exp_n, exp_r;
    logic              round_up;
    logic [24:0]       mant_r;
    logic [22:0]       frac_r;
    logic [31:0]       packed_res;

    always_comb begin
        exp_n    = $signed({2'b00, s1_exp_q}) + $signed({9'd0, carry}) - $signed({5'd0, lzc});
        // RNE: round up above half, or at exactly half when the LSB is odd.
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (mant_r[24]) begin
            exp_r  = exp_n + 10'sd1;
            frac_r = mant_r[23:1];
        end else begin
            exp_r  = exp_n;
            frac_r = mant_r[22:0];
        end

        if (s1_special_q) begin
            packed_res = s1_special_res_q;
        end else if (sum_zero) begin
            packed_res = '0;
        end else if (exp_r >= 10'sd255) begin
            packed_res = {s1_sign_q, EXP_MAX, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            packed_res = {s1_sign_q, 31'd0};
        end else begin
            packed_res = {s1_sign_q, exp_r[7:0], frac_r};
        end
    end

    logic        out_valid_q;
    logic [31:0] result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= packed_res;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_fp_add.sv
module tb_fp_add;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] result;

    int passed;
    int total;

    fp_add dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand pair and capture the outputs two edges later (no checking here).
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic v);
        in_valid = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        r = result;
        v = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid);
        else passed++;
        total++;
        if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result);
        else passed++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [31:0] vx[4];
        logic [31:0] vy[4];
        logic [31:0] ve[4];
        logic [31:0] r;
        logic        v;
        vx[0] = 32'h3f115b57; vy[0] = 32'h3fab851f; ve[0] = 32'h3ff432ca;
        vx[1] = 32'h3f800000; vy[1] = 32'h40000000; ve[1] = 32'h40400000;
        vx[2] = 32'h3f800000; vy[2] = 32'hc0000000; ve[2] = 32'hbf800000;
        vx[3] = 32'h00000001; vy[3] = 32'h3f800000; ve[3] = 32'h3f800000;

        // Latency: not valid after only one edge.
        in_valid = 1'b1;
        a = vx[0];
        b = vy[0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL latency_early: got %b expected 0", out_valid);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || result !== ve[0])
            $display("FAIL latency_basic: got v=%b %h expected v=1 %h", out_valid, result, ve[0]);
        else passed++;

        for (int i = 1; i < 4; i++) begin
            run_op(vx[i], vy[i], r, v);
            total++;
            if (v !== 1'b1 || r !== ve[i])
                $display("FAIL basic_%0d: got v=%b %h expected v=1 %h", i, v, r, ve[i]);
            else passed++;
        end
    endtask

    task automatic test_zeros();
        logic [31:0] vx[5];
        logic [31:0] vy[5];
        logic [31:0] ve[5];
        logic [31:0] r;
        logic        v;
        vx[0] = 32'h00000000; vy[0] = 32'h3fab851f; ve[0] = 32'h3fab851f;
        vx[1] = 32'h00000000; vy[1] = 32'h00000000; ve[1] = 32'h00000000;
        vx[2] = 32'h80000000; vy[2] = 32'h80000000; ve[2] = 32'h80000000;
        vx[3] = 32'h80000000; vy[3] = 32'h00000000; ve[3] = 32'h00000000;
        vx[4] = 32'h3f800000; vy[4] = 32'h80000000; ve[4] = 32'h3f800000;
        for (int i = 0; i < 5; i++) begin
            run_op(vx[i], vy[i], r, v);
            total++;
            if (v !== 1'b1 || r !== ve[i])
                $display("FAIL zero_%0d: got v=%b %h expected v=1 %h", i, v, r, ve[i]);
            else passed++;
        end
    endtask

    task automatic test_rounding();
        logic [31:0] vx[5];
        logic [31:0] vy[5];
        logic [31:0] ve[5];
        logic [31:0] r;
        logic        v;
        vx[0] = 32'h3aa137f4; vy[0] = 32'h3c4985f0; ve[0] = 32'h3c5dacee; // tie to even
        vx[1] = 32'h3f800000; vy[1] = 32'h33800000; ve[1] = 32'h3f800000; // tie, even stays
        vx[2] = 32'h3f800001; vy[2] = 32'h33800000; ve[2] = 32'h3f800002; // tie, odd rounds up
        vx[3] = 32'h3f800000; vy[3] = 32'h32800000; ve[3] = 32'h3f800000; // shift >= 26
        vx[4] = 32'h3fffffff; vy[4] = 32'h33800000; ve[4] = 32'h40000000; // rounding carry
        for (int i = 0; i < 5; i++) begin
            run_op(vx[i], vy[i], r, v);
            total++;
            if (v !== 1'b1 || r !== ve[i])
                $display("FAIL round_%0d: got v=%b %h expected v=1 %h", i, v, r, ve[i]);
            else passed++;
        end
    endtask

    task automatic test_specials();
        logic [31:0] vx[8];
        logic [31:0] vy[8];
        logic [31:0] ve[8];
        logic [31:0] r;
        logic        v;
        vx[0] = 32'h3f800000; vy[0] = 32'hbf800000; ve[0] = 32'h00000000; // cancellation
        vx[1] = 32'h7f800000; vy[1] = 32'hff800000; ve[1] = 32'h7fc00000; // inf - inf
        vx[2] = 32'h7f7fffff; vy[2] = 32'h7f7fffff; ve[2] = 32'h7f800000; // overflow
        vx[3] = 32'h7f800001; vy[3] = 32'h3f800000; ve[3] = 32'h7fc00000; // NaN in
        vx[4] = 32'h7f800000; vy[4] = 32'h3f800000; ve[4] = 32'h7f800000; // inf + finite
        vx[5] = 32'hff800000; vy[5] = 32'h7f7fffff; ve[5] = 32'hff800000;
        vx[6] = 32'h80800001; vy[6] = 32'h00800000; ve[6] = 32'h80000000; // underflow flush
        vx[7] = 32'hff7fffff; vy[7] = 32'hff7fffff; ve[7] = 32'hff800000;
        for (int i = 0; i < 8; i++) begin
            run_op(vx[i], vy[i], r, v);
            total++;
            if (v !== 1'b1 || r !== ve[i])
                $display("FAIL special_%0d: got v=%b %h expected v=1 %h", i, v, r, ve[i]);
            else passed++;
        end
    endtask

    task automatic test_hold();
        logic [31:0] r;
        logic        v;
        run_op(32'h3f800000, 32'h40000000, r, v);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 32'h40400000)
            $display("FAIL hold: got v=%b %h expected v=0 40400000", out_valid, result);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vx[6];
        logic [31:0] vy[6];
        logic [31:0] ve[6];
        vx[0] = 32'h3f115b57; vy[0] = 32'h3fab851f; ve[0] = 32'h3ff432ca;
        vx[1] = 32'h00000000; vy[1] = 32'h3fab851f; ve[1] = 32'h3fab851f;
        vx[2] = 32'h3aa137f4; vy[2] = 32'h3c4985f0; ve[2] = 32'h3c5dacee;
        vx[3] = 32'h3f800000; vy[3] = 32'hbf800000; ve[3] = 32'h00000000;
        vx[4] = 32'h7f800000; vy[4] = 32'hff800000; ve[4] = 32'h7fc00000;
        vx[5] = 32'h7f7fffff; vy[5] = 32'h7f7fffff; ve[5] = 32'h7f800000;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                in_valid = 1'b1;
                a = vx[i];
                b = vy[i];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i >= 1) begin
                total++;
                if (out_valid !== 1'b1 || result !== ve[i-1])
                    $display("FAIL stream_%0d: got v=%b %h expected v=1 %h",
                             i - 1, out_valid, result, ve[i-1]);
                else passed++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [31:0] r;
        logic        v;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 32'h3f800000;
            b = 32'h40000000;
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 32'h0)
            $display("FAIL midrst_now: got v=%b %h expected v=0 00000000", out_valid, result);
        else passed++;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0 || result !== 32'h0)
                $display("FAIL midrst_stale_%0d: got v=%b %h expected v=0 00000000",
                         i, out_valid, result);
            else passed++;
        end
        run_op(32'h3f800000, 32'h3f800000, r, v);
        total++;
        if (v !== 1'b1 || r !== 32'h40000000)
            $display("FAIL midrst_first: got v=%b %h expected v=1 40000000", v, r);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_basic();
        test_zeros();
        test_rounding();
        test_specials();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
